uart_tx_scheduler: RTL and testbench

- Shares one UART transmit line between NUM_REQ byte-stream requesters using round-robin arbitration.
- Serialises the granted byte as an 8N1 or 8N2 frame, with an optional parity bit.
- Sits beside the 16x-oversampling baud tick generator:
  - consumes that generator's tick;
  - drives its start_tx restart pulse so that every frame begins bit-aligned.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width and the default
// oversample rate that both transmitter and receiver are built for.
package uart_pkg;

  localparam int DATA_BITS           = 8;
  localparam int SAMPLE_RATE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after (last grant + 1).
// The pointer moves only when the caller strobes advance with a request pending.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int               cand;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // Reset parks the pointer on the last requester so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (advance && (|req)) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter (8 data bits, 1 or 2 stop bits).
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit after the data.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEFAULT,
  parameter int STOP_BITS   = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][7:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       start_tx,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SC_W  = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  tx_state_t            state;
  tx_state_t            state_d;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_idx_d;
  logic                 stop_cnt;
  logic                 stop_cnt_d;
  logic [SC_W-1:0]      sample_cnt;
  logic [DATA_BITS-1:0] data_q;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 grant_now;
  logic                 tick_en;
  logic                 bit_done;
  logic                 tx_d;
  logic                 busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .advance   (grant_now),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign grant_now = (state == IDLE) && (|req_valid);
  // start_tx is high exactly in the grant cycle, while the generator restarts.
  assign tick_en   = tick && !start_tx && (state != IDLE);
  assign bit_done  = tick_en && (sample_cnt == SC_W'(SAMPLE_RATE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_d;
      bit_idx  <= bit_idx_d;
      stop_cnt <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_idx_d  = bit_idx;
    stop_cnt_d = stop_cnt;
    case (state)
      IDLE: begin
        if (grant_now) begin
          state_d    = START;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_SCHED_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) state_d = IDLE;
          else                               stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so tx and state change on the same edge;
  // the line stays high through the grant cycle and drops one cycle later.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = grant_now;
      DATA:    tx_d = data_q[bit_idx_d];
      PARITY:  tx_d = ^data_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || grant_now) begin
      sample_cnt <= '0;
    end else if (tick_en) begin
      sample_cnt <= bit_done ? '0 : sample_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_now) data_q <= req_data[arb_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      req_ready <= '0;
      start_tx  <= 1'b0;
      grant_id  <= '0;
    end else begin
      tx        <= tx_d;
      busy      <= busy_d;
      req_ready <= grant_now ? arb_grant : '0;
      start_tx  <= grant_now;
      if (grant_now) grant_id <= arb_idx;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: one instance with one stop bit, one with two,
// random oversample ticks, frames checked against a bit-list model.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int SR   = 16;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic                 clock;
  logic                 reset;
  logic                 tick;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      ready1, ready2, ready_m;
  logic                 start1, start2, start_tx_m;
  logic                 tx1, tx2, tx_m;
  logic                 busy1, busy2, busy_m;
  logic [1:0]           gid1, gid2, gid_m;

  bit  sel;
  bit  tick_always;
  bit  tick_in_grant;
  int  checks;
  int  failures;
  int  last;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .SAMPLE_RATE(SR), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .tick(tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(ready1), .start_tx(start1), .tx(tx1),
    .busy(busy1), .grant_id(gid1));

  uart_tx_scheduler #(.NUM_REQ(NREQ), .SAMPLE_RATE(SR), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .tick(tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(ready2), .start_tx(start2), .tx(tx2),
    .busy(busy2), .grant_id(gid2));

  assign ready_m    = sel ? ready2 : ready1;
  assign start_tx_m = sel ? start2 : start1;
  assign tx_m       = sel ? tx2    : tx1;
  assign busy_m     = sel ? busy2  : busy1;
  assign gid_m      = sel ? gid2   : gid1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tick = tick_always ? 1'b1 : ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: first valid requester at or after (last grant + 1).
  function automatic int pick(input logic [NREQ-1:0] v, input int lst);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(lst + i) % NREQ]) return (lst + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clock);
    check("rst_tx",       32'(tx_m),       32'd1);
    check("rst_busy",     32'(busy_m),     32'd0);
    check("rst_ready",    32'(ready_m),    32'd0);
    check("rst_start_tx", 32'(start_tx_m), 32'd0);
    check("rst_grant_id", 32'(gid_m),      32'd0);
    reset = 1'b0;
    last  = NREQ - 1;
  endtask

  // Waits for a grant, then walks the expected line levels, each held for SR ticks.
  task automatic recv_frame(input int exp_id, input logic [7:0] b, input bit drop,
                            output int gap);
    logic lv[$];
    int   n, err, cyc, sb;
    sb = sel ? 2 : 1;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    if (PAR) lv.push_back(^b);
    for (int i = 0; i < sb; i++) lv.push_back(1'b1);

    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (!start_tx_m && gap < 3000);
    check("grant_seen", 32'(start_tx_m), 32'd1);
    if (!start_tx_m) return;
    check("grant_ready", 32'(ready_m), 32'(4'b0001 << exp_id));
    check("grant_id",    32'(gid_m),   32'(exp_id));
    check("grant_busy",  32'(busy_m),  32'd1);
    check("grant_tx",    32'(tx_m),    32'd1);
    tick_in_grant = tick;
    if (drop) req_valid[exp_id] = 1'b0;

    err = 0;
    cyc = 0;
    foreach (lv[s]) begin
      n = 0;
      while (n < SR && cyc < 20000) begin
        @(negedge clock);
        cyc++;
        if (tx_m !== lv[s] || busy_m !== 1'b1 || ready_m !== '0 || start_tx_m !== 1'b0)
          err++;
        if (tick) n++;
      end
    end
    if (cyc >= 20000) err++;
    check("frame_cycles_bad", 32'(err), 32'd0);
    @(negedge clock);
    check("end_busy", 32'(busy_m), 32'd0);
    check("end_tx",   32'(tx_m),   32'd1);
    last = exp_id;
  endtask

  initial begin
    int          gap, w, n, e;
    logic [7:0]  byte3;
    logic [7:0]  bytes4 [4];
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    sel         = 1'b0;
    tick_always = 1'b0;
    last        = NREQ - 1;

    do_reset();

    // Single byte from requester 2.
    req_data[2]  = 8'hA5;
    req_valid[2] = 1'b1;
    recv_frame(2, 8'hA5, 1'b1, gap);

    // All four requesters at once, round-robin from 0.
    do_reset();
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int r = 0; r < NREQ; r++) req_data[r] = bytes4[r];
    req_valid = 4'b1111;
    for (int r = 0; r < NREQ; r++) begin
      e = pick(req_valid, last);
      check("rr_model_order", 32'(e), 32'(r));
      recv_frame(r, bytes4[r], 1'b1, gap);
      if (r > 0) check("rr_gap", 32'(gap), 32'd1);
    end

    // Fairness: 0 and 3 held valid throughout.
    req_data[0] = 8'($urandom);
    req_data[3] = 8'($urandom);
    req_valid   = 4'b1001;
    for (int f = 0; f < 4; f++) begin
      e = (f % 2 == 0) ? 0 : 3;
      recv_frame(e, req_data[e], 1'b0, gap);
      if (f == 3) req_valid = '0;
    end

    // Random arrivals and withdrawals against the arbitration model.
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
          req_data[r]  = 8'($urandom);
          req_valid[r] = 1'b1;
        end else if (req_valid[r] && $urandom_range(0, 3) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      if (req_valid == '0) begin
        req_data[f % NREQ]  = 8'($urandom);
        req_valid[f % NREQ] = 1'b1;
      end
      e = pick(req_valid, last);
      recv_frame(e, req_data[e], 1'b1, gap);
      check("rand_gap", 32'(gap), 32'd1);
    end
    req_valid = '0;

    // Reset in the middle of data bit 4.
    byte3        = 8'($urandom);
    req_data[3]  = byte3;
    req_valid[3] = 1'b1;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!start_tx_m && w < 100);
    check("abort_grant_id", 32'(gid_m), 32'd3);
    req_valid[3] = 1'b0;
    n = 0;
    w = 0;
    while (n < SR + 4 * SR + 5 && w < 20000) begin
      @(negedge clock);
      w++;
      if (tick) n++;
    end
    check("abort_bit4_level", 32'(tx_m), 32'(byte3[4]));
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx",    32'(tx_m),    32'd1);
    check("abort_busy",  32'(busy_m),  32'd0);
    check("abort_ready", 32'(ready_m), 32'd0);
    reset = 1'b0;
    last  = NREQ - 1;
    req_data[1]  = 8'($urandom);
    req_valid[1] = 1'b1;
    recv_frame(1, req_data[1], 1'b1, gap);

    // Two stop bits with a tick present in the grant cycle.
    do_reset();
    sel          = 1'b1;
    tick_always  = 1'b1;
    req_data[0]  = 8'($urandom);
    req_valid[0] = 1'b1;
    recv_frame(0, req_data[0], 1'b1, gap);
    check("grant_cycle_tick", 32'(tick_in_grant), 32'd1);
    tick_always = 1'b0;
    sel         = 1'b0;

    // Parity frame (parity period present only when compiled in).
    do_reset();
    req_data[2]  = 8'h07;
    req_valid[2] = 1'b1;
    recv_frame(2, 8'h07, 1'b1, gap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
